// File: rtl/exmem_pipe_if.sv
// EX->MEM pipeline handshake bundle: upstream valid/ready + payload, downstream valid/ready + payload.
// Signal names are from the pipeline register's point of view (_i into it, _o out of it).
// slave = the pipeline register itself, master = the surrounding EX/MEM logic (or a bench).
interface exmem_pipe_if #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WB_W-1:0]   wb_i;
  logic [M_W-1:0]    m_i;
  logic [DATA_W-1:0] alu_i;
  logic [DATA_W-1:0] wdata_i;
  logic [RD_W-1:0]   rd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WB_W-1:0]   wb_o;
  logic [M_W-1:0]    m_o;
  logic [DATA_W-1:0] alu_o;
  logic [DATA_W-1:0] wdata_o;
  logic [RD_W-1:0]   rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  in_valid_i, wb_i, m_i, alu_i, wdata_i, rd_i, out_ready_i,
    output in_ready_o, out_valid_o, wb_o, m_o, alu_o, wdata_o, rd_o, stall_cnt_o
  );

  modport master (
    output in_valid_i, wb_i, m_i, alu_i, wdata_i, rd_i, out_ready_i,
    input  in_ready_o, out_valid_o, wb_o, m_o, alu_o, wdata_o, rd_o, stall_cnt_o
  );
endinterface

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid buffer and a saturating back-pressure counter.
// Latency: 1 cycle from accept to out_valid_o when the main register is free (or popping).
// Backpressure: in_ready_o is registered and drops only once the skid entry is occupied.
module exmem_pipe #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  exmem_pipe_if.slave bus
);
  localparam int PW = WB_W + M_W + 2 * DATA_W + RD_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [PW-1:0]     main_q, skid_q, in_pay;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, pop, out_vld;
  logic              load_main_in, load_main_skid, load_skid;

  logic [WB_W-1:0]   main_wb;
  logic [M_W-1:0]    main_m;
  logic [DATA_W-1:0] main_alu, main_wdata;
  logic [RD_W-1:0]   main_rd;

  // The main entry is valid in ONE and TWO; the skid entry only in TWO.
  assign out_vld = (state_q != EMPTY);
  assign accept  = bus.in_valid_i & in_ready_q;
  assign pop     = out_vld & bus.out_ready_i;
  assign in_pay  = {bus.wb_i, bus.m_i, bus.alu_i, bus.wdata_i, bus.rd_i};

  assign {main_wb, main_m, main_alu, main_wdata, main_rd} = main_q;

  // Control fields are masked on bubbles so an idle MEM/WB never writes anything.
  assign bus.out_valid_o = out_vld;
  assign bus.in_ready_o  = in_ready_q;
  assign bus.wb_o        = out_vld ? main_wb : '0;
  assign bus.m_o         = out_vld ? main_m  : '0;
  assign bus.alu_o       = main_alu;
  assign bus.wdata_o     = main_wdata;
  assign bus.rd_o        = main_rd;
  assign bus.stall_cnt_o = cnt_q;

  // Next-state and load selects; flush discards everything including a same-cycle accept.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
    // Ready is computed from the next state so it never depends combinationally on out_ready_i.
    in_ready_d = (state_d != TWO);
  end

  // State, ready flag and both payload registers; reset wins over flush, accept and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      if (load_main_in) begin
        main_q <= in_pay;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pay;
      end
    end
  end

  // Back-pressure counter: counts cycles an entry is offered but refused, saturating, survives flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (out_vld && !bus.out_ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: doc/exmem_pipe.md
EXMEM_PIPE -- requirements
Module: exmem_pipe

Interface
REQ-001 Parameter WB_W, default 2, width of write-back control field.
REQ-002 Parameter M_W, default 2, width of memory control field.
REQ-003 Parameter DATA_W, default 32, width of ALU result and store-data fields.
REQ-004 Parameter RD_W, default 5, width of destination register index.
REQ-005 Parameter CNT_W, default 16, width of stall counter.
REQ-006 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-007 Port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-008 Port rst_i, input, 1, synchronous active-high reset.
REQ-009 Port flush_i, input, 1, discard all held entries.
REQ-010 Port in_valid_i, input, 1, upstream (EX) entry valid.
REQ-011 Port in_ready_o, output, 1, block can accept an entry this cycle.
REQ-012 Ports wb_i / m_i / alu_i / wdata_i / rd_i, input, WB_W / M_W / DATA_W / DATA_W / RD_W, EX-stage payload.
REQ-013 Port out_valid_o, output, 1, MEM-side entry valid.
REQ-014 Port out_ready_i, input, 1, downstream (MEM) accepts entry.
REQ-015 Ports wb_o / m_o / alu_o / wdata_o / rd_o, output, same widths, registered payload.
REQ-016 Port stall_cnt_o, output, CNT_W, count of back-pressured cycles.

Function
REQ-017 Storage SHALL be two entries: main register (drives outputs) and skid register; each carries a valid bit.
REQ-018 States SHALL be EMPTY (no valid entry), ONE (main valid, skid empty), TWO (both valid).
REQ-019 in_ready_o SHALL be registered and equal 1 exactly when the skid is empty (EMPTY or ONE); no combinational path from out_ready_i to in_ready_o.
REQ-020 Accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
REQ-021 EMPTY: accept -> ONE, main loaded; no accept -> stay EMPTY.
REQ-022 ONE: accept & pop -> ONE, main loaded with input; accept & !pop -> TWO, skid loaded; !accept & pop -> EMPTY; neither -> hold.
REQ-023 TWO: pop -> ONE, main loaded from skid; !pop -> hold (no accept possible).
REQ-024 Latency SHALL be one cycle from accept in EMPTY (or ONE with pop) to out_valid_o=1 with that payload.
REQ-025 Entries SHALL leave in acceptance order; none lost or duplicated.
REQ-026 Every payload field, including rd_i, SHALL be captured from its input port at accept.
REQ-027 wb_o and m_o SHALL read 0 whenever out_valid_o=0 (bubble never writes register file or memory); alu_o, wdata_o, rd_o keep last main contents.
REQ-028 flush_i=1 SHALL clear both valid bits next cycle, go to EMPTY, set in_ready_o=1, and override any same-cycle accept.
REQ-029 stall_cnt_o SHALL increment by 1 each cycle with out_valid_o=1 and out_ready_i=0, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-030 rst_i=1 SHALL on the next edge force EMPTY, out_valid_o=0, in_ready_o=1, all payload outputs 0, stall_cnt_o=0.
REQ-031 rst_i SHALL override flush_i, accept and pop in the same cycle, including mid-operation in state TWO.

Verification
REQ-032 Reset then in_valid_i=1, alu_i=32'h0000_1234, rd_i=5'd7, out_ready_i=1 -> next cycle out_valid_o=1, alu_o=32'h0000_1234, rd_o=7.
REQ-033 out_ready_i=0, push A then B -> after B in_ready_o=0, out_valid_o=1 showing A; raise out_ready_i -> A then B on consecutive cycles, in_ready_o=1 after A pops.
REQ-034 State TWO, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, wb_o=0, m_o=0, in_ready_o=1, incoming entry discarded.
REQ-035 Continuous in_valid_i=1 and out_ready_i=1 for 100 cycles, incrementing alu_i -> 100 in-order outputs, in_ready_o never 0.
REQ-036 CNT_W=4, hold out_ready_i=0 with valid entry for 20 cycles -> stall_cnt_o stops at 15.
REQ-037 State TWO, rst_i=1 together with out_ready_i=1 -> next cycle EMPTY, all outputs 0, stall_cnt_o=0.
